// File: rtl/gpu_pkg.sv
// Constants and types shared between the GPU slave and its bus initiators.
// Framebuffer geometry, register addresses and the fill-master state encoding.
package gpu_pkg;

  localparam logic [14:0] FB_WORDS            = 15'd15000;
  localparam logic [13:0] WORDS_PER_LINE      = 14'd25;
  localparam logic [23:0] FB_BASE_ADDR        = 24'h000000;
  localparam logic [23:0] REG_PIX_OFFSET_ADDR = 24'h050000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_FILL,
    ST_OFFSET,
    ST_DONE
  } fill_state_t;

  // Byte address of a framebuffer word; always word-aligned.
  function automatic logic [23:0] word_addr(input logic [13:0] idx);
    return FB_BASE_ADDR + {8'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/gpu_line_tracker.sv
// Tracks column and line parity of the current fill word for checkerboard fills.
// Loads the start word, divides it by WORDS_PER_LINE through repeated subtraction, then steps per word.
module gpu_line_tracker
  import gpu_pkg::*;
(
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] start_word,
  input  logic        prep,
  input  logic        advance,
  output logic        prep_done,
  output logic        odd_line
);

  logic [13:0] col_q;
  logic        odd_q;

  // col_q holds the running remainder during PREP and the column afterwards.
  assign prep_done = (col_q < WORDS_PER_LINE);
  assign odd_line  = odd_q;

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      odd_q <= 1'b0;
    end else if (load) begin
      col_q <= start_word;
      odd_q <= 1'b0;
    end else if (prep && !prep_done) begin
      col_q <= col_q - WORDS_PER_LINE;
      odd_q <= ~odd_q;
    end else if (advance) begin
      if (col_q == WORDS_PER_LINE - 14'd1) begin
        col_q <= '0;
        odd_q <= ~odd_q;
      end else begin
        col_q <= col_q + 14'd1;
      end
    end
  end

endmodule

// File: rtl/gpu_fill_master.sv
// Bus initiator that fills a run of framebuffer words and optionally writes REG_PIX_OFFSET.
// Define GPU_FILL_CHECKER_EN to invert the pattern on odd framebuffer lines (checkerboard fill).
module gpu_fill_master
  import gpu_pkg::*;
(
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [13:0] cmd_start_word,
  input  logic [13:0] cmd_word_count,
  input  logic [31:0] cmd_pattern,
  input  logic        cmd_set_offset,
  input  logic [31:0] cmd_offset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        bus_read,
  output logic        bus_write,
  output logic [23:0] bus_address,
  output logic [31:0] bus_data_o,
  input  logic        bus_stall
);

  fill_state_t state_q, state_d;

  logic [13:0] word_q;
  logic [13:0] remaining_q;
  logic [31:0] pattern_q;
  logic [31:0] offset_q;
  logic        set_offset_q;
  logic        error_q;
  logic [31:0] fill_data;

  logic accept;
  logic in_range;
  logic xfer_done;

  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = ({1'b0, cmd_start_word} + {1'b0, cmd_word_count}) <= FB_WORDS;
  assign xfer_done = bus_write && !bus_stall;

`ifdef GPU_FILL_CHECKER_EN
  logic prep_done;
  logic odd_line;

  gpu_line_tracker u_line_tracker (
    .clk_bus    (clk_bus),
    .rst_n      (rst_n),
    .load       (accept),
    .start_word (cmd_start_word),
    .prep       (state_q == ST_PREP),
    .advance    ((state_q == ST_FILL) && xfer_done),
    .prep_done  (prep_done),
    .odd_line   (odd_line)
  );

  assign fill_data = odd_line ? ~pattern_q : pattern_q;
`else
  assign fill_data = pattern_q;
`endif

  // NOTE: state is only ever written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      remaining_q  <= '0;
      pattern_q    <= '0;
      offset_q     <= '0;
      set_offset_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= accept && !in_range;
      if (accept) begin
        word_q       <= cmd_start_word;
        remaining_q  <= cmd_word_count;
        pattern_q    <= cmd_pattern;
        offset_q     <= cmd_offset;
        set_offset_q <= cmd_set_offset;
      end else if ((state_q == ST_FILL) && xfer_done) begin
        word_q      <= word_q + 14'd1;
        remaining_q <= remaining_q - 14'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && in_range) begin
          if (cmd_word_count == 14'd0) begin
            state_d = cmd_set_offset ? ST_OFFSET : ST_DONE;
          end else begin
`ifdef GPU_FILL_CHECKER_EN
            state_d = ST_PREP;
`else
            state_d = ST_FILL;
`endif
          end
        end
      end
      ST_PREP: begin
`ifdef GPU_FILL_CHECKER_EN
        if (prep_done) state_d = ST_FILL;
`else
        state_d = ST_FILL;
`endif
      end
      ST_FILL: begin
        if (xfer_done && (remaining_q == 14'd1)) begin
          state_d = set_offset_q ? ST_OFFSET : ST_DONE;
        end
      end
      ST_OFFSET: begin
        if (xfer_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registers, so a stall holds them stable and
  // an asynchronous reset clears them without waiting for a clock edge.
  always_comb begin
    bus_address = '0;
    bus_data_o  = '0;
    case (state_q)
      ST_FILL: begin
        bus_address = word_addr(word_q);
        bus_data_o  = fill_data;
      end
      ST_OFFSET: begin
        bus_address = REG_PIX_OFFSET_ADDR;
        bus_data_o  = offset_q;
      end
      default: begin
        bus_address = '0;
        bus_data_o  = '0;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign bus_read  = 1'b0;
  assign bus_write = (state_q == ST_FILL) || (state_q == ST_OFFSET);

endmodule

// File: tb/tb_gpu_fill_master.sv
// Self-checking bench for gpu_fill_master: directed corner cases plus randomized commands
// compared against a list-of-writes reference model (honours GPU_FILL_CHECKER_EN).
module tb_gpu_fill_master;

  logic        clk_bus = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [13:0] cmd_start_word = '0;
  logic [13:0] cmd_word_count = '0;
  logic [31:0] cmd_pattern = '0;
  logic        cmd_set_offset = 1'b0;
  logic [31:0] cmd_offset = '0;
  logic        busy, done, error, bus_read, bus_write;
  logic [23:0] bus_address;
  logic [31:0] bus_data_o;
  logic        bus_stall = 1'b0;

  gpu_fill_master dut (
    .clk_bus        (clk_bus),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_start_word (cmd_start_word),
    .cmd_word_count (cmd_word_count),
    .cmd_pattern    (cmd_pattern),
    .cmd_set_offset (cmd_set_offset),
    .cmd_offset     (cmd_offset),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_address    (bus_address),
    .bus_data_o     (bus_data_o),
    .bus_stall      (bus_stall)
  );

  always #5 clk_bus = ~clk_bus;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge view equals what the next edge commits.
  int          cyc = 0;
  int          wr_cycles = 0, done_cnt = 0, err_cnt = 0, hold_viol = 0, addr4_cycles = 0;
  int          acc_cyc = 0, rise_cyc = 0, last_comp_cyc = 0, done_cyc = 0;
  logic        prev_wr = 1'b0, prev_stall_wr = 1'b0;
  logic [55:0] prev_ad = '0;
  logic [55:0] got_q[$];

  always @(negedge clk_bus) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_wr       <= 1'b0;
      prev_stall_wr <= 1'b0;
    end else begin
      if (prev_stall_wr && (!bus_write || {bus_address, bus_data_o} != prev_ad))
        hold_viol <= hold_viol + 1;
      prev_stall_wr <= bus_write && bus_stall;
      prev_ad       <= {bus_address, bus_data_o};
      prev_wr       <= bus_write;
      if (cmd_valid && cmd_ready) acc_cyc <= cyc;
      if (bus_write && !prev_wr) rise_cyc <= cyc;
      if (bus_write) wr_cycles <= wr_cycles + 1;
      if (bus_write && bus_address == 24'd4) addr4_cycles <= addr4_cycles + 1;
      if (bus_write && !bus_stall) begin
        got_q.push_back({bus_address, bus_data_o});
        last_comp_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (error) err_cnt <= err_cnt + 1;
    end
  end

  // Reference model: the list of writes a command must produce.
  logic [55:0] exp_q[$];
  bit          exp_err;
  int          prep_extra;
  int          base_got, base_done, base_err, base_wr;

  function automatic int prep_cycles(input int s, input int c);
`ifdef GPU_FILL_CHECKER_EN
    return (c == 0) ? 0 : s / 25 + 1;
`else
    return 0;
`endif
  endfunction

  task automatic build_model(input int s, input int c, input logic [31:0] p, input bit so,
                             input logic [31:0] off);
    logic [31:0] d;
    exp_q.delete();
    exp_err    = (s + c > 15000);
    prep_extra = prep_cycles(s, c);
    if (exp_err) return;
    for (int i = 0; i < c; i++) begin
      d = p;
`ifdef GPU_FILL_CHECKER_EN
      if (((s + i) / 25) % 2 == 1) d = ~p;
`endif
      exp_q.push_back({24'((s + i) * 4), d});
    end
    if (so) exp_q.push_back({24'h050000, off});
  endtask

  task automatic issue_cmd(input logic [13:0] s, input logic [13:0] c, input logic [31:0] p,
                           input bit so, input logic [31:0] off);
    build_model(int'(s), int'(c), p, so, off);
    @(posedge clk_bus); #2;
    base_got  = got_q.size();
    base_done = done_cnt;
    base_err  = err_cnt;
    base_wr   = wr_cycles;
    cmd_start_word = s;
    cmd_word_count = c;
    cmd_pattern    = p;
    cmd_set_offset = so;
    cmd_offset     = off;
    cmd_valid      = 1'b1;
    @(posedge clk_bus); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input bit rnd_stall);
    int n = 0;
    while (done_cnt == base_done && err_cnt == base_err && n < 20000) begin
      if (rnd_stall) bus_stall = ($urandom_range(0, 3) == 0);
      @(posedge clk_bus); #2;
      n++;
    end
    bus_stall = 1'b0;
    check("timeout", 64'(n < 20000), 64'd1);
    repeat (3) @(posedge clk_bus);
    #2;
    check("ready_after", 64'(cmd_ready), 64'd1);
  endtask

  task automatic verify(input string name, input bit timing);
    int ng = got_q.size() - base_got;
    check({name, "_nwrites"}, 64'(ng), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      check({name, "_write"}, 64'(got_q[base_got + i]), 64'(exp_q[i]));
    check({name, "_done"}, 64'(done_cnt - base_done), 64'(exp_err ? 0 : 1));
    check({name, "_error"}, 64'(err_cnt - base_err), 64'(exp_err));
    if (timing && !exp_err && exp_q.size() > 0) begin
      check({name, "_latency"}, 64'(rise_cyc), 64'(acc_cyc + 1 + prep_extra));
      check({name, "_wrcycles"}, 64'(wr_cycles - base_wr), 64'(exp_q.size()));
      check({name, "_donecyc"}, 64'(done_cyc), 64'(last_comp_cyc + 1));
    end
  endtask

  initial begin
    logic [13:0] s, c;
    int          frozen;

    #12;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_outs", 64'({busy, done, error, bus_read, bus_write}), 64'd0);
    check("rst_bus", 64'({bus_address, bus_data_o}), 64'd0);
    @(posedge clk_bus); #2;
    rst_n = 1'b1;

    issue_cmd(14'd0, 14'd1, 32'haaaaaaaa, 1'b0, 32'd0);
    wait_end(1'b0);
    verify("single0", 1'b1);

    issue_cmd(14'd14999, 14'd1, 32'h55555555, 1'b0, 32'd0);
    wait_end(1'b0);
    verify("lastword", 1'b1);
    check("lastword_addr", 64'(got_q[base_got][55:32]), 64'h00EA5C);

    issue_cmd(14'd0, 14'd0, 32'h12345678, 1'b1, 32'd50);
    wait_end(1'b0);
    verify("offset_only", 1'b0);

    issue_cmd(14'd30, 14'd4, 32'hdeadbeef, 1'b1, 32'd7);
    wait_end(1'b0);
    verify("fill_offset", 1'b1);

    // Stall word 1 for two cycles: word 1 goes out as soon as word 0 completes.
    issue_cmd(14'd0, 14'd3, 32'h0badf00d, 1'b0, 32'd0);
    frozen = addr4_cycles;
`ifdef GPU_FILL_CHECKER_EN
    repeat (prep_extra) @(posedge clk_bus);
`endif
    @(posedge clk_bus); #2;
    bus_stall = 1'b1;
    @(posedge clk_bus);
    @(posedge clk_bus); #2;
    bus_stall = 1'b0;
    wait_end(1'b0);
    verify("stall", 1'b0);
    check("stall_wrcycles", 64'(wr_cycles - base_wr), 64'd5);
    check("stall_addr4", 64'(addr4_cycles - frozen), 64'd3);

    issue_cmd(14'd14990, 14'd20, 32'hffffffff, 1'b1, 32'd1);
    wait_end(1'b0);
    verify("reject", 1'b0);
    check("reject_nowrite", 64'(wr_cycles - base_wr), 64'd0);

`ifdef GPU_FILL_CHECKER_EN
    issue_cmd(14'd24, 14'd2, 32'h0F0F0F0F, 1'b0, 32'd0);
    wait_end(1'b0);
    verify("checker", 1'b1);
`endif

    for (int k = 0; k < 10; k++) begin
      c = 14'($urandom_range(0, 40));
      s = (k % 3 == 2) ? 14'(15000 - int'(c) + int'($urandom_range(0, 1)))
                       : 14'($urandom_range(0, 14999));
      issue_cmd(s, c, $urandom, 1'($urandom), $urandom);
      wait_end(1'b1);
      verify("random", 1'b0);
    end
    check("stall_hold", 64'(hold_viol), 64'd0);

    // Reset mid-fill: outputs must clear between clock edges and the fill is dropped.
    issue_cmd(14'd100, 14'd200, 32'hcafef00d, 1'b1, 32'd3);
    repeat (10) @(posedge clk_bus);
    #2;
    check("midfill_active", 64'(bus_write), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_write", 64'(bus_write), 64'd0);
    check("midrst_bus", 64'({bus_address, bus_data_o}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk_bus); #2;
    rst_n = 1'b1;
    frozen = got_q.size();
    repeat (8) @(posedge clk_bus);
    #2;
    check("postrst_nowrite", 64'(got_q.size()), 64'(frozen));
    check("postrst_nodone", 64'(done_cnt - base_done), 64'd0);
    check("postrst_idle", 64'(cmd_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpu_fill_master.md
# gpu_fill_master

Bus initiator that drives the GPU's slave bus port on `clk_bus`. It accepts a fill command, writes a run of 32-bit framebuffer words with a fill pattern, and optionally writes the pixel-offset (scroll) register afterwards. Every transfer honours `bus_stall`. It sits between the CPU-side command logic and the `gpu` block. It replaces hand-sequenced CPU stores for clears, test patterns and scroll updates.

## Interface
- `FB_WORDS`, 15000, framebuffer size in 32-bit words (800x600, 1 bit per pixel).
- `WORDS_PER_LINE`, 25, words per 800-pixel line.
- `OFFSET_ADDR`, 24'h50000, byte address of REG_PIX_OFFSET.
- `clk_bus` in 1: bus clock; the block's only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block idle; command accepted on `cmd_valid && cmd_ready`.
- `cmd_start_word` in 14: first word index.
- `cmd_word_count` in 14: number of words to fill; 0 means no fill.
- `cmd_pattern` in 32: fill data.
- `cmd_set_offset` in 1: write REG_PIX_OFFSET after the fill.
- `cmd_offset` in 32: value for REG_PIX_OFFSET, in words.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.
- `error` out 1: one-cycle pulse when a command is rejected.
- `bus_read` out 1: tied 0.
- `bus_write` out 1: write request.
- `bus_address` out 24: byte address, always word-aligned.
- `bus_data_o` out 32: write data; connects to the gpu's `bus_data_i`.
- `bus_stall` in 1: slave not ready; current request must be held.

## Operation
- States: IDLE, PREP, FILL, OFFSET, DONE.
- **IDLE:** `cmd_ready` = 1. On accept, latch all `cmd_*` inputs.
- **Range check at accept:** if `start + count > FB_WORDS`, using 15-bit arithmetic, pulse `error` the next cycle, stay in IDLE, and issue no bus write.
- **Transitions after a valid accept:**
  - Go to PREP when the macro is compiled in; otherwise go to FILL.
  - If count = 0, go to OFFSET when `cmd_set_offset` = 1, else go to DONE.
- **FILL:** `bus_write` = 1, `bus_address` = word_index*4, `bus_data_o` = pattern (modified per Configuration).
  - A transfer completes on a clock edge where `bus_write` = 1 and `bus_stall` = 0. On completion: word_index += 1, remaining -= 1.
  - After the last word, go to OFFSET if `cmd_set_offset` = 1, else go to DONE.
- **OFFSET:** `bus_write` = 1, `bus_address` = `OFFSET_ADDR`, `bus_data_o` = `cmd_offset`. On completion, go to DONE.
- **DONE:** `done` = 1 for one cycle, then return to IDLE.
- **Outputs in IDLE and DONE:** `bus_write` = 0; `bus_address` and `bus_data_o` are 0.
- **Stall:** while `bus_stall` = 1, `bus_address` and `bus_data_o` are held stable and `bus_write` stays 1. A stall is never a reason to drop a request.
- **Reset (including mid-command):** asynchronous. Every output goes to 0 immediately, except `cmd_ready`, which goes to 1. The state goes to IDLE. A partially written fill is abandoned and not resumed.
- `cmd_valid` outside IDLE is ignored.

## Timing
- **Accept to first request:** 1 cycle without the macro.
- **Fill duration:** N words with no stall take exactly N consecutive cycles of `bus_write` = 1.
- **Offset write:** starts in the cycle after the last fill completion.
- **Completion:** `done` is asserted in the cycle after the final completion. `cmd_ready` rises in the following cycle.
- `busy` = 1 from the cycle after accept through the DONE cycle.
- **Rejection:** `error` pulses the cycle after a rejected accept. `cmd_ready` stays 1.

## Configuration
- **`GPU_FILL_CHECKER_EN` defined:**
  - PREP computes the line parity and column of the start word by iterative subtraction of `WORDS_PER_LINE`, one subtraction per cycle, so PREP takes floor(start/25)+1 cycles.
  - In FILL, words on odd framebuffer lines carry ~pattern. The column counter wraps at 24 and toggles the parity on wrap.
- **`GPU_FILL_CHECKER_EN` not defined:**
  - PREP is unreachable and data is always `cmd_pattern`.
  - The line tracker sub-module is not instantiated.

## Structure
- **Shared package `gpu_pkg`:**
  - `FB_WORDS`, `WORDS_PER_LINE` and `REG_PIX_OFFSET_ADDR`.
  - The state enum type for IDLE, PREP, FILL, OFFSET, DONE.
  - Any other bus address constants shared with `gpu`.
- **Sub-module `gpu_line_tracker`:** holds the column/parity counter together with the PREP divide-by-subtraction.

## Test plan
- **Single word at 0:** start 0, count 1, pattern 32'haaaaaaaa, no offset -> one write to addr 0 with data aaaaaaaa; `done` on the next cycle.
- **Last framebuffer word:** start 14999, count 1, pattern 32'h55555555 -> one write to addr 24'h00EA5C; no further writes.
- **Offset only:** count 0, set_offset, offset 50 -> exactly one write, addr 24'h50000, data 32'd50.
- **Stall hold:** start 0, count 3, `bus_stall` high for 2 cycles during word 1 -> addr 4 and its data held for 3 cycles; 5 write cycles total; 3 completions.
- **Range reject:** start 14990, count 20 -> `error` pulse; `bus_write` never asserted. Then reset mid-fill -> `bus_write` drops with no clock edge.
- **Checker (macro defined):** start 24, count 2, pattern 32'h0F0F0F0F -> addr 96 data 0F0F0F0F, then addr 100 data F0F0F0F0.
